// File: rtl/regfile_neg.sv
// Falling-edge register file: one write port, two combinational read ports, r0 hardwired to zero.
// Writes are visible after the falling edge of the same cycle; there is no backpressure.
module regfile_neg #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]  data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]  data_readRegA,
    output logic [WIDTH-1:0]  data_readRegB
);

    // No storage exists for r0; its reads are forced to zero in the muxes.
    logic [WIDTH-1:0] regs [1:DEPTH-1];
    logic [DEPTH-1:1] wr_dec;

    always_comb begin
        wr_dec = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr_dec[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i));
        end
    end

    always_ff @(negedge clock or posedge clr) begin
        if (clr) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_dec[i]) begin
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    always_comb begin
        data_readRegA = '0;
        data_readRegB = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ctrl_readRegA == ADDR_W'(i)) begin
                data_readRegA = regs[i];
            end
            if (ctrl_readRegB == ADDR_W'(i)) begin
                data_readRegB = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_neg.sv
// Directed bench for regfile_neg: expected read values are queued from a reference model and popped at each check.
module tb_regfile_neg;

    logic        clock;
    logic        clr;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];
    logic [31:0] sb [$];

    regfile_neg #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clock            (clock),
        .clr              (clr),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
            return;
        end
        exp = sb.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Drive a write across one falling edge, update the model, release the enable.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] dat);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = addr;
        data_writeReg    = dat;
        @(negedge clock);
        if (addr != 5'd0 && !clr) model[addr] = dat;
        #1;
        ctrl_writeEnable = 1'b0;
    endtask

    task automatic read_pair(input string tag, input logic [4:0] a, input logic [4:0] b);
        ctrl_readRegA = a;
        ctrl_readRegB = b;
        sb.push_back(model[a]);
        sb.push_back(model[b]);
        #1;
        chk({tag, "_A"}, data_readRegA);
        chk({tag, "_B"}, data_readRegB);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            read_pair(tag, 5'(i), 5'(31 - i));
        end
    endtask

    initial begin
        clr              = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;
        model_clear();

        #2 clr = 1'b1;
        #10 clr = 1'b0;
        sweep("reset");

        do_write(5'd5, 32'hDEADBEEF);
        read_pair("r5", 5'd5, 5'd5);
        sweep("after_r5");

        do_write(5'd0, 32'hFFFFFFFF);
        read_pair("r0_guard", 5'd0, 5'd0);
        sweep("after_r0");

        // Read-during-write: old value before the falling edge, new value after it.
        @(posedge clock);
        #1;
        ctrl_readRegA    = 5'd7;
        ctrl_readRegB    = 5'd7;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h12345678;
        sb.push_back(32'h0);
        #1;
        chk("fwd_before", data_readRegA);
        @(negedge clock);
        model[7] = 32'h12345678;
        #1;
        sb.push_back(32'h12345678);
        sb.push_back(32'h12345678);
        chk("fwd_after_A", data_readRegA);
        chk("fwd_after_B", data_readRegB);
        ctrl_writeEnable = 1'b0;
        @(posedge clock);
        #1;
        read_pair("fwd_next_rise", 5'd7, 5'd5);

        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'hAAAA5555;
        repeat (4) @(negedge clock);
        #1;
        read_pair("we_gate", 5'd9, 5'd9);

        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h01010101);
        end
        sweep("fill");

        do_write(5'd3, 32'h0BADF00D);
        read_pair("r3_load", 5'd3, 5'd31);

        // Async clear between edges: outputs must drop without a clock edge.
        @(posedge clock);
        #1;
        ctrl_readRegA = 5'd3;
        ctrl_readRegB = 5'd31;
        clr = 1'b1;
        model_clear();
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        #1;
        chk("clr_async_A", data_readRegA);
        chk("clr_async_B", data_readRegB);
        #1 clr = 1'b0;

        // Clear held across a falling edge that also carries a write to r3.
        @(posedge clock);
        #1;
        clr = 1'b1;
        do_write(5'd3, 32'hCAFEBABE);
        read_pair("clr_vs_write", 5'd3, 5'd3);
        clr = 1'b0;

        do_write(5'd3, 32'h00000001);
        read_pair("post_clr", 5'd3, 5'd0);
        sweep("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
